// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared FIR constants and tap controller state type
//
// Purpose : constants shared by `fir` and `fir_tap_ctrl`, plus the state
//           encoding of the tap controller.
// Contents: FIR_NUM_TAPS, FIR_TAP_W, tap_ctrl_state_t.
package fir_pkg;

  localparam int FIR_NUM_TAPS = 4;
  localparam int FIR_TAP_W    = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    DRAIN  = 3'd2,
    ARMED  = 3'd3,
    SETTLE = 3'd4
  } tap_ctrl_state_t;

endpackage

// File: rtl/tap_shadow_bank.sv
// rtl/tap_shadow_bank.sv - NUM_TAPS x TAP_W register file with indexed write
//
// Purpose : holds a tap set while it is being streamed in.
// Ports   : clock, reset     - clock, synchronous active-high reset
//           wr_en_i          - write strobe
//           wr_idx_i         - entry written
//           wr_data_i        - value written
//           rd_data_o        - all entries, entry i at [i*TAP_W +: TAP_W]
module tap_shadow_bank #(
  parameter int NUM_TAPS = 4,
  parameter int TAP_W    = 3,
  parameter int IDX_W    = $clog2(NUM_TAPS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      wr_en_i,
  input  logic [IDX_W-1:0]          wr_idx_i,
  input  logic [TAP_W-1:0]          wr_data_i,
  output logic [NUM_TAPS*TAP_W-1:0] rd_data_o
);

  logic [TAP_W-1:0] mem_q [NUM_TAPS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  for (genvar g = 0; g < NUM_TAPS; g++) begin : g_rd
    assign rd_data_o[g*TAP_W +: TAP_W] = mem_q[g];
  end

endmodule

// File: rtl/fir_tap_ctrl.sv
// rtl/fir_tap_ctrl.sv - streamed coefficient loader with atomic swap for `fir`
//
// Purpose : collects a tap set into a shadow bank, swaps it into the active
//           taps on a sample tick and mutes the filter while the delay line
//           refills.
// Ports   : clock, reset           - clock, synchronous active-high reset
//           sample_tick           - cycle in which `fir` consumes a sample
//           cfg_valid/ready/data/last - coefficient beat stream, tap 0 first
//           taps                  - active taps, tap i at [i*TAP_W +: TAP_W]
//           mute, busy            - output invalid / not idle
//           done, err_len         - reload complete / malformed set pulses
//           reload_count, err_count - only with FIR_TAP_CTRL_STATS_EN
module fir_tap_ctrl
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = FIR_NUM_TAPS,
  parameter int TAP_W    = FIR_TAP_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      sample_tick,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [TAP_W-1:0]          cfg_data,
  input  logic                      cfg_last,
  output logic [NUM_TAPS*TAP_W-1:0] taps,
  output logic                      mute,
  output logic                      busy,
  output logic                      done,
`ifdef FIR_TAP_CTRL_STATS_EN
  output logic                      err_len,
  output logic [7:0]                reload_count,
  output logic [7:0]                err_count
`else
  output logic                      err_len
`endif
);

  localparam int IDX_W = $clog2(NUM_TAPS);
  localparam int CNT_W = $clog2(NUM_TAPS + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_TAPS - 1);
  localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(NUM_TAPS);

  tap_ctrl_state_t           state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_TAPS*TAP_W-1:0] taps_q, taps_d;
  logic                      mute_q, mute_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;

  logic                      beat;
  logic                      shadow_we;
  logic [IDX_W-1:0]          shadow_idx;
  logic [NUM_TAPS*TAP_W-1:0] shadow_taps;

  assign cfg_ready = (state_q == IDLE) || (state_q == LOAD) || (state_q == DRAIN);
  assign beat      = cfg_valid && cfg_ready;

  // Beats taken in IDLE always land in entry 0; idx_q only tracks LOAD.
  assign shadow_we  = beat && ((state_q == IDLE) || (state_q == LOAD));
  assign shadow_idx = (state_q == IDLE) ? '0 : idx_q;

  tap_shadow_bank #(
    .NUM_TAPS (NUM_TAPS),
    .TAP_W    (TAP_W),
    .IDX_W    (IDX_W)
  ) u_shadow (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (shadow_we),
    .wr_idx_i  (shadow_idx),
    .wr_data_i (cfg_data),
    .rd_data_o (shadow_taps)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    taps_d  = taps_q;
    mute_d  = mute_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat) begin
          if (cfg_last) begin
            err_d = 1'b1;
          end else begin
            idx_d   = IDX_W'(1);
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (cfg_last) begin
              state_d = ARMED;
            end else begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end
          end else if (cfg_last) begin
            idx_d   = '0;
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (beat && cfg_last) begin
          state_d = IDLE;
        end
      end
      ARMED: begin
        // Whole set moves on one edge so `fir` never sees a mixed set.
        if (sample_tick) begin
          taps_d  = shadow_taps;
          cnt_d   = SETTLE_INIT;
          mute_d  = 1'b1;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // One tick per delay-line slot until every product uses new taps.
        if (sample_tick) begin
          if (cnt_q == CNT_W'(1)) begin
            cnt_d   = '0;
            mute_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      taps_q  <= '0;
      mute_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      taps_q  <= taps_d;
      mute_q  <= mute_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign taps    = taps_q;
  assign mute    = mute_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign err_len = err_q;

`ifdef FIR_TAP_CTRL_STATS_EN
  logic [7:0] reload_cnt_q;
  logic [7:0] err_cnt_q;

  // 8-bit counters wrap 255->0 naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      reload_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      if (done_q) reload_cnt_q <= reload_cnt_q + 8'd1;
      if (err_q)  err_cnt_q    <= err_cnt_q + 8'd1;
    end
  end

  assign reload_count = reload_cnt_q;
  assign err_count    = err_cnt_q;
`endif

endmodule

// File: tb/tb_fir_tap_ctrl.sv
// tb/tb_fir_tap_ctrl.sv - self-checking bench for fir_tap_ctrl
module tb_fir_tap_ctrl;
  import fir_pkg::*;

  localparam int N = FIR_NUM_TAPS;
  localparam int W = FIR_TAP_W;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           sample_tick = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  logic [W-1:0]   cfg_data = '0;
  logic           cfg_last = 1'b0;
  logic [N*W-1:0] taps;
  logic           mute, busy, done, err_len;
`ifdef FIR_TAP_CTRL_STATS_EN
  logic [7:0]     reload_count, err_count;
`endif

  fir_tap_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_data     (cfg_data),
    .cfg_last     (cfg_last),
    .taps         (taps),
    .mute         (mute),
    .busy         (busy),
    .done         (done),
`ifdef FIR_TAP_CTRL_STATS_EN
    .err_len      (err_len),
    .reload_count (reload_count),
    .err_count    (err_count)
`else
    .err_len      (err_len)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int exp_taps[N];
  int pend_taps[N];
  int good_loads = 0;
  int bad_loads = 0;

  function automatic logic [N*W-1:0] pack_exp();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'(exp_taps[i]);
    return r;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) exp_taps[i] = 0;
    checks += 6;
    if (taps !== pack_exp()) begin failures++; $display("FAIL reset_taps got=%h exp=%h", taps, pack_exp()); end
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    if (mute !== 1'b0) begin failures++; $display("FAIL reset_mute got=%b exp=0", mute); end
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    if (err_len !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_len); end
  endtask

  // Streams one beat per cycle; the model judges each beat only by how many
  // beats of the current set have arrived and where cfg_last falls.
  task automatic send_set(input int data[$], input int lasts[$], input bit tick_on_last,
                          output bit ok_set);
    int  cnt = 0;
    bit  discarding = 0;
    bit  exp_err;
    bit  exp_busy;
    ok_set = 0;
    for (int k = 0; k < data.size(); k++) begin
      cfg_valid   = 1'b1;
      cfg_data    = W'(data[k]);
      cfg_last    = lasts[k] != 0;
      sample_tick = tick_on_last && (k == data.size() - 1);
      checks++;
      if (cfg_ready !== 1'b1) begin failures++; $display("FAIL beat_ready k=%0d got=%b exp=1", k, cfg_ready); end
      exp_err = 0;
      if (discarding) begin
        if (lasts[k] != 0) discarding = 0;
      end else begin
        pend_taps[cnt] = data[k];
        cnt++;
        if (lasts[k] != 0) begin
          if (cnt == N) ok_set = 1; else exp_err = 1;
          cnt = 0;
        end else if (cnt == N) begin
          exp_err = 1;
          discarding = 1;
          cnt = 0;
        end
      end
      exp_busy = discarding || (cnt > 0) || ok_set;
      if (exp_err) bad_loads++;
      step();
      cfg_valid   = 1'b0;
      cfg_last    = 1'b0;
      sample_tick = 1'b0;
      checks += 4;
      if (err_len !== exp_err) begin failures++; $display("FAIL beat_err k=%0d got=%b exp=%b", k, err_len, exp_err); end
      if (busy !== exp_busy) begin failures++; $display("FAIL beat_busy k=%0d got=%b exp=%b", k, busy, exp_busy); end
      if (taps !== pack_exp()) begin failures++; $display("FAIL beat_taps k=%0d got=%h exp=%h", k, taps, pack_exp()); end
      if (done !== 1'b0) begin failures++; $display("FAIL beat_done k=%0d got=%b exp=0", k, done); end
    end
  endtask

  // From ARMED: optional wait, swap tick, then N settle ticks with gaps.
  task automatic swap_and_settle(input int arm_wait, input int gap_max, input bit hold_valid);
    for (int c = 0; c < arm_wait; c++) begin
      if (hold_valid) begin
        cfg_valid = 1'b1;
        cfg_data  = W'($urandom_range(0, (1 << W) - 1));
        cfg_last  = $urandom_range(0, 1) != 0;
      end
      step();
      checks += 3;
      if (cfg_ready !== 1'b0) begin failures++; $display("FAIL armed_ready c=%0d got=%b exp=0", c, cfg_ready); end
      if (taps !== pack_exp()) begin failures++; $display("FAIL armed_taps c=%0d got=%h exp=%h", c, taps, pack_exp()); end
      if (busy !== 1'b1) begin failures++; $display("FAIL armed_busy c=%0d got=%b exp=1", c, busy); end
    end
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int i = 0; i < N; i++) exp_taps[i] = pend_taps[i];
    checks += 2;
    if (taps !== pack_exp()) begin failures++; $display("FAIL swap_taps got=%h exp=%h", taps, pack_exp()); end
    if (mute !== 1'b1) begin failures++; $display("FAIL swap_mute got=%b exp=1", mute); end
    for (int t = 1; t <= N; t++) begin
      int gap = $urandom_range(0, gap_max);
      for (int g = 0; g < gap; g++) begin
        step();
        checks += 3;
        if (mute !== 1'b1) begin failures++; $display("FAIL gap_mute t=%0d got=%b exp=1", t, mute); end
        if (done !== 1'b0) begin failures++; $display("FAIL gap_done t=%0d got=%b exp=0", t, done); end
        if (cfg_ready !== 1'b0) begin failures++; $display("FAIL gap_ready t=%0d got=%b exp=0", t, cfg_ready); end
      end
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      cfg_valid   = 1'b0;
      checks += 5;
      if (mute !== (t < N)) begin failures++; $display("FAIL settle_mute t=%0d got=%b exp=%b", t, mute, t < N); end
      if (done !== (t == N)) begin failures++; $display("FAIL settle_done t=%0d got=%b exp=%b", t, done, t == N); end
      if (busy !== (t < N)) begin failures++; $display("FAIL settle_busy t=%0d got=%b exp=%b", t, busy, t < N); end
      if (err_len !== 1'b0) begin failures++; $display("FAIL settle_err t=%0d got=%b exp=0", t, err_len); end
      if (taps !== pack_exp()) begin failures++; $display("FAIL settle_taps t=%0d got=%h exp=%h", t, taps, pack_exp()); end
    end
    step();
    checks += 2;
    if (done !== 1'b0) begin failures++; $display("FAIL done_width got=%b exp=0", done); end
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL idle_ready got=%b exp=1", cfg_ready); end
    good_loads++;
  endtask

  task automatic test_basic_load();
    int d[$] = {1, 1, 2, 2};
    int l[$] = {0, 0, 0, 1};
    bit ok;
    send_set(d, l, 1'b0, ok);
    checks++;
    if (ok !== 1'b1) begin failures++; $display("FAIL basic_model got=%b exp=1", ok); end
    swap_and_settle(0, 0, 1'b0);
  endtask

  task automatic test_short_set();
    int d[$] = {3, 5};
    int l[$] = {0, 1};
    bit ok;
    send_set(d, l, 1'b0, ok);
    step();
    checks += 3;
    if (err_len !== 1'b0) begin failures++; $display("FAIL short_err_width got=%b exp=0", err_len); end
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL short_ready got=%b exp=1", cfg_ready); end
    if (busy !== 1'b0) begin failures++; $display("FAIL short_busy got=%b exp=0", busy); end
  endtask

  task automatic test_long_set();
    int d[$] = {7, 7, 7, 7, 6, 6};
    int l[$] = {0, 0, 0, 0, 0, 1};
    bit ok;
    send_set(d, l, 1'b0, ok);
    step();
    checks += 2;
    if (err_len !== 1'b0) begin failures++; $display("FAIL long_err_width got=%b exp=0", err_len); end
    if (busy !== 1'b0) begin failures++; $display("FAIL long_busy got=%b exp=0", busy); end
  endtask

  task automatic test_armed_wait();
    int d[$];
    int l[$];
    bit ok;
    for (int i = 0; i < N; i++) begin
      d.push_back($urandom_range(0, (1 << W) - 1));
      l.push_back(i == N - 1);
    end
    // Tick coincident with the final beat must not swap.
    send_set(d, l, 1'b1, ok);
    swap_and_settle(20, 2, 1'b1);
  endtask

  task automatic test_reset_mid();
    int d[$] = {5, 6, 7, 4};
    int l[$] = {0, 0, 0, 1};
    bit ok;
    send_set(d, l, 1'b0, ok);
    sample_tick = 1'b1;
    for (int t = 0; t < 3; t++) step();
    sample_tick = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) exp_taps[i] = 0;
    good_loads = 0;
    bad_loads  = 0;
    checks += 5;
    if (taps !== pack_exp()) begin failures++; $display("FAIL rst_mid_taps got=%h exp=%h", taps, pack_exp()); end
    if (mute !== 1'b0) begin failures++; $display("FAIL rst_mid_mute got=%b exp=0", mute); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    if (cfg_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", cfg_ready); end
    if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%b exp=0", done); end
    step();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_done2 got=%b exp=0", done); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      int d[$];
      int l[$];
      int len;
      bit ok;
      int kind = $urandom_range(0, 2);
      case (kind)
        0: len = N;
        1: len = $urandom_range(1, N - 1);
        default: len = $urandom_range(N + 1, N + 3);
      endcase
      for (int i = 0; i < len; i++) begin
        d.push_back($urandom_range(0, (1 << W) - 1));
        l.push_back(i == len - 1);
      end
      send_set(d, l, 1'b0, ok);
      if (ok) swap_and_settle($urandom_range(0, 3), 3, 1'b0);
      else step();
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_short_set();
    test_long_set();
    test_armed_wait();
    test_reset_mid();
    test_random();
`ifdef FIR_TAP_CTRL_STATS_EN
    step();
    checks += 2;
    if (reload_count !== 8'(good_loads)) begin failures++; $display("FAIL reload_count got=%0d exp=%0d", reload_count, good_loads); end
    if (err_count !== 8'(bad_loads)) begin failures++; $display("FAIL err_count got=%0d exp=%0d", err_count, bad_loads); end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
